// File: rtl/counter_scan_ctrl_pkg.sv
// Shared constants for the counter scan controller: state encoding,
// default frame header and the channel-to-mux-select mapping.
package counter_scan_ctrl_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HDR  = 3'd1;
  localparam logic [2:0] ST_SEL  = 3'd2;
  localparam logic [2:0] ST_SMP  = 3'd3;
  localparam logic [2:0] ST_SEND = 3'd4;
  localparam logic [2:0] ST_CSUM = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;
  localparam logic [3:0] MUX_SEL_MAX      = 4'd15;

  // The counter mux is wired in reverse: channel ch sits on input 15 - ch.
  function automatic logic [3:0] ch_to_mux_sel(input logic [3:0] ch);
    return MUX_SEL_MAX - ch;
  endfunction

endpackage

// File: rtl/counter_scan_ctrl.sv
// Scans NUM_CH counters through an external 16:1 mux and streams a frame of
// header, one byte per channel and an XOR checksum to a serial transmitter.
module counter_scan_ctrl
  import counter_scan_ctrl_pkg::*;
#(
  parameter int         NUM_CH   = 16,
  parameter logic [7:0] HDR_BYTE = HDR_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       continuous,
  output logic [3:0] mux_sel,
  input  logic [7:0] counter_mux,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [3:0] LAST_CH = 4'(NUM_CH - 1);

  logic [2:0] state_reg, state_next;
  logic [3:0] ch_reg;
  logic [3:0] mux_sel_reg;
  logic [7:0] sample_reg;
  logic [7:0] checksum_reg;
  logic       last_ch;
  logic       hdr_entry;

  assign last_ch   = (ch_reg == LAST_CH);
  assign hdr_entry = (state_next == ST_HDR) && (state_reg != ST_HDR);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_HDR;
      ST_HDR:  if (tx_ready) state_next = ST_SEL;
      ST_SEL:  state_next = ST_SMP;
      ST_SMP:  state_next = ST_SEND;
      ST_SEND: if (tx_ready) state_next = last_ch ? ST_CSUM : ST_SEL;
      ST_CSUM: if (tx_ready) state_next = ST_DONE;
      ST_DONE: state_next = continuous ? ST_HDR : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      ch_reg       <= 4'd0;
      mux_sel_reg  <= MUX_SEL_MAX;
      sample_reg   <= 8'd0;
      checksum_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      if (hdr_entry) begin
        ch_reg       <= 4'd0;
        checksum_reg <= 8'd0;
      end
      if (state_reg == ST_HDR && tx_ready) begin
        mux_sel_reg <= ch_to_mux_sel(4'd0);
      end
      // Sample after the SEL settle cycle; later counter changes cannot leak in.
      if (state_reg == ST_SMP) begin
        sample_reg   <= counter_mux;
        checksum_reg <= checksum_reg ^ counter_mux;
      end
      if (state_reg == ST_SEND && tx_ready && !last_ch) begin
        ch_reg      <= ch_reg + 4'd1;
        mux_sel_reg <= ch_to_mux_sel(ch_reg + 4'd1);
      end
    end
  end

  // Outputs decode from registered state only, so they hold while stalled
  // and fall to reset values as soon as rst_n drops.
  always_comb begin
    tx_data  = 8'd0;
    tx_valid = 1'b0;
    case (state_reg)
      ST_HDR:  begin tx_data = HDR_BYTE;     tx_valid = 1'b1; end
      ST_SEND: begin tx_data = sample_reg;   tx_valid = 1'b1; end
      ST_CSUM: begin tx_data = checksum_reg; tx_valid = 1'b1; end
      default: begin tx_data = 8'd0;         tx_valid = 1'b0; end
    endcase
  end

  assign mux_sel    = mux_sel_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_counter_scan_ctrl.sv
// Scoreboard bench for counter_scan_ctrl: stimulus queues expected bytes,
// a negedge monitor pops and compares every accepted transmitter byte.
module tb_counter_scan_ctrl;

  localparam int NUM_CH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic       tx_ready = 1'b1;
  logic [3:0] mux_sel;
  logic [7:0] counter_mux;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       frame_done;

  logic [7:0] cnt [16];

  always #5 clk = ~clk;

  assign counter_mux = cnt[4'd15 - mux_sel];

  counter_scan_ctrl #(.NUM_CH(NUM_CH), .HDR_BYTE(8'hA5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .continuous  (continuous),
    .mux_sel     (mux_sel),
    .counter_mux (counter_mux),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  typedef struct {
    logic [7:0] data;
    logic [3:0] sel;
    bit         chk_sel;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   hdr_cyc = 0;
  int   last_latency = -1;
  int   rdy_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // tx_ready driver: mode 0 always ready, mode 1 random, mode 2 left to the stimulus
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) tx_ready = 1'b1;
    else if (rdy_mode == 1) tx_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: compares accepted bytes against the scoreboard and checks stall stability
  initial begin
    exp_t       e;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       busy_prev;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    busy_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        busy_prev  = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(tx_valid), 32'd1);
          check("stall_data", 32'(tx_data), 32'(prev_data));
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got %0h, expected no byte", tx_data);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e.data));
            if (e.chk_sel) check("mux_sel", 32'(mux_sel), 32'(e.sel));
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (busy && !busy_prev) hdr_cyc = cyc;
        busy_prev = busy;
        if (frame_done) begin
          done_cnt++;
          last_latency = cyc - hdr_cyc + 1;
        end
      end
    end
  end

  // Queue one frame: header, the channel bytes from cnt[], then the hand-computed checksum.
  task automatic push_frame(input logic [7:0] csum);
    exp_t e;
    e.data = 8'hA5; e.sel = 4'd0; e.chk_sel = 1'b0;
    exp_q.push_back(e);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      e.data = cnt[ch]; e.sel = 4'(15 - ch); e.chk_sel = 1'b1;
      exp_q.push_back(e);
    end
    e.data = csum; e.sel = 4'd0; e.chk_sel = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) @(posedge clk);
    @(negedge clk);
    check("frame_done_count", 32'(done_cnt), 32'(target));
  endtask

  task automatic check_idle(input string name);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({name, "_tx_data"}, 32'(tx_data), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_frame_done"}, 32'(frame_done), 32'd0);
    check({name, "_mux_sel"}, 32'(mux_sel), 32'd15);
  endtask

  initial begin
    int base;
    for (int i = 0; i < 16; i++) cnt[i] = 8'h00;

    // Reset state, then confirm the block idles without a start pulse
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("idle_after_reset_busy", 32'(busy), 32'd0);
    check("idle_after_reset_done", 32'(done_cnt), 32'd0);

    // Ramp 00..0F, ready high: checksum 00, frame_done 51 cycles after HDR entry
    for (int i = 0; i < 16; i++) cnt[i] = 8'(i);
    push_frame(8'h00);
    pulse_start();
    wait_done(1, 500);
    check("latency", 32'(last_latency), 32'd51);
    check_idle("ramp");

    // All FF: checksum 00
    for (int i = 0; i < 16; i++) cnt[i] = 8'hFF;
    push_frame(8'h00);
    pulse_start();
    wait_done(2, 500);
    check_idle("all_ff");

    // Only ch0 = 5A: checksum 5A; a start while busy must not alter or queue a frame
    for (int i = 0; i < 16; i++) cnt[i] = 8'h00;
    cnt[0] = 8'h5A;
    push_frame(8'h5A);
    pulse_start();
    repeat (10) @(posedge clk);
    pulse_start();
    wait_done(3, 500);
    check_idle("single_5a");
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("no_queued_start", 32'(done_cnt), 32'd3);

    // Values 01..10 with random tx_ready: checksum 10
    for (int i = 0; i < 16; i++) cnt[i] = 8'(i + 1);
    rdy_mode = 1;
    push_frame(8'h10);
    pulse_start();
    wait_done(4, 2000);
    rdy_mode = 0;
    check_idle("random_ready");

    // Continuous: two back-to-back frames, continuous dropped during frame 2
    continuous = 1'b1;
    push_frame(8'h10);
    push_frame(8'h10);
    pulse_start();
    wait_done(5, 500);
    repeat (8) @(posedge clk);
    #1 continuous = 1'b0;
    wait_done(6, 500);
    check_idle("continuous");

    // Reset during channel 7 SEND aborts the frame without frame_done
    for (int i = 0; i < 16; i++) cnt[i] = 8'(i);
    push_frame(8'h00);
    pulse_start();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() <= 10) break;
    end
    rdy_mode = 2;
    @(posedge clk);
    #2 tx_ready = 1'b0;
    for (int i = 0; i < 20 && !tx_valid; i++) @(negedge clk);
    @(negedge clk);
    check("ch7_send_valid", 32'(tx_valid), 32'd1);
    check("ch7_send_data", 32'(tx_data), 32'h07);
    check("ch7_send_mux_sel", 32'(mux_sel), 32'd8);
    base = done_cnt;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tx_ready = 1'b1;
    rdy_mode = 0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("after_abort_busy", 32'(busy), 32'd0);
    check("after_abort_done", 32'(done_cnt), 32'(base));
    push_frame(8'h00);
    pulse_start();
    wait_done(base + 1, 500);
    check_idle("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

endmodule

// File: doc/counter_scan_ctrl.md
COUNTER_SCAN_CTRL -- requirements
Module: counter_scan_ctrl

Interface
REQ-001 Parameter NUM_CH, default 16: channels scanned per frame (2..16).
REQ-002 Parameter HDR_BYTE, default 8'hA5: frame header byte.
REQ-003 clk  input  1  single system clock; all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  single-cycle frame request.
REQ-006 continuous  input  1  level; when high, start a new frame on completion without a new start pulse.
REQ-007 mux_sel  output  4  select to the 16:1 counter mux; channel ch is mux_sel = 15 - ch.
REQ-008 counter_mux  input  8  selected counter value from the mux.
REQ-009 tx_data  output  8  byte stream to the serial transmitter.
REQ-010 tx_valid  output  1  tx_data valid.
REQ-011 tx_ready  input  1  transmitter accepts the byte when tx_valid && tx_ready.
REQ-012 busy  output  1  high whenever state != IDLE.
REQ-013 frame_done  output  1  one-cycle pulse after the checksum byte is accepted.

Function
REQ-014 States: IDLE, HDR, SEL, SMP, SEND, CSUM, DONE.
REQ-015 IDLE -> HDR on start=1; start while busy is ignored (not queued).
REQ-016 HDR: tx_data = HDR_BYTE and tx_valid = 1, held stable until accepted, then -> SEL with ch = 0.
REQ-017 SEL: mux_sel = 15 - ch, one settle cycle, then -> SMP.
REQ-018 SMP: latch counter_mux into the sample register, XOR it into the checksum, then -> SEND.
REQ-019 SEND: tx_data = sample and tx_valid = 1 until accepted; then ch+1 -> SEL if ch < NUM_CH-1, else -> CSUM.
REQ-020 CSUM: tx_data = XOR of all NUM_CH data bytes (header excluded) and tx_valid = 1 until accepted, then -> DONE.
REQ-021 DONE: frame_done = 1 for one cycle; -> HDR if continuous = 1, else -> IDLE.
REQ-022 Checksum register and ch clear to 0 on entry to HDR.
REQ-023 tx_data and tx_valid do not change while tx_valid = 1 and tx_ready = 0.
REQ-024 A transfer completes only on a cycle with tx_valid && tx_ready; tx_ready already high on the first valid cycle completes that cycle.
REQ-025 Frame length: NUM_CH + 2 bytes. Minimum frame latency with tx_ready held high: 3*NUM_CH + 3 cycles from HDR entry to frame_done.
REQ-026 Each channel is sampled exactly once per frame, in order ch 0..NUM_CH-1. Counter changes after SMP do not affect the sent byte.
REQ-027 mux_sel holds its last value outside SEL and SMP.
REQ-028 Dropping continuous mid-frame completes the current frame, then returns to IDLE.

Reset
REQ-029 While rst_n = 0: state = IDLE, ch = 0, mux_sel = 4'd15, sample = 0, checksum = 0, tx_data = 0, tx_valid = 0, busy = 0, frame_done = 0.
REQ-030 Reset asserted mid-frame aborts the frame immediately; no partial-frame completion and no frame_done.
REQ-031 After reset release, the block stays in IDLE until a start pulse.

Structure
REQ-032 A shared package holds the state enum encoding, HDR_BYTE default, and the channel-to-mux_sel mapping constant (15 - ch).
REQ-033 No sub-module. The state machine, channel counter, sample register and checksum register sit in one module driving the existing counter mux.

Verification
REQ-034 Counters ch0..ch15 = 8'h00..8'h0F, tx_ready = 1, single start -> bytes A5, 00, 01 .. 0F, then checksum 8'h00; frame_done at cycle 51 after HDR entry.
REQ-035 Counters all 8'hFF, NUM_CH = 16 -> 16 bytes FF, then checksum 8'h00; counters ch0 = 8'h5A, others 0 -> checksum 8'h5A.
REQ-036 tx_ready toggling pseudo-randomly -> tx_data and tx_valid stable while stalled, no byte lost or duplicated, checksum correct.
REQ-037 continuous = 1 with one start -> back-to-back frames, each starting with A5; continuous dropped during frame 2 -> frame 2 completes, then IDLE.
REQ-038 rst_n pulsed low during channel 7 SEND -> all outputs at reset values asynchronously, no frame_done; next start yields a full, correct frame.
REQ-039 Mapping check: mux_sel sequence observed in SEL is 15, 14, .. 0; a start pulse while busy does not alter the frame.
